// File: rtl/mem_stage_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl_pkg
// Shared types for the MEM stage controller and its bus interface.
//   word_t          : 32-bit datapath word
//   regbits_t       : 5-bit register index
//   memctrl_state_t : MEM stage FSM state
//   memreq_t        : dcache request latched from EX/MEM while the access runs
//   memwb_t         : MEM/WB write-back word
// ----------------------------------------------------------------------------
package mem_stage_ctrl_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } memctrl_state_t;

  typedef struct packed {
    logic     ren;
    logic     wen;
    word_t    addr;
    word_t    data;
    logic     regwr;
    logic     memtoreg;
    regbits_t regdst;
    word_t    pc_add4;
  } memreq_t;

  typedef struct packed {
    logic     valid;
    logic     regwr;
    regbits_t regdst;
    word_t    wdata;
    word_t    pc_add4;
  } memwb_t;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl_if
// Bundles the EX/MEM control word, the dcache request/response pair and the
// MEM/WB write-back word seen by the MEM stage controller.
//   master : the MEM stage controller (issues dcache requests, drives MEM/WB)
//   slave  : the surroundings (EX/MEM register, dcache, write-back stage)
// ----------------------------------------------------------------------------
interface mem_stage_ctrl_if;
  import mem_stage_ctrl_pkg::*;

  // EX/MEM register contents
  logic     ex_valid;
  logic     ex_dREN;
  logic     ex_dWEN;
  word_t    ex_portOut;
  word_t    ex_portB_fwd;
  logic     ex_regWr;
  logic     ex_memToReg;
  regbits_t ex_regDst;
  logic     ex_halt;
  word_t    ex_pc_add4;

  // dcache
  logic     dhit;
  word_t    dmemload;
  logic     dmemREN;
  logic     dmemWEN;
  word_t    dmemaddr;
  word_t    dmemstore;

  // pipeline control and MEM/WB
  logic     mem_stall;
  logic     wb_valid;
  logic     wb_regWr;
  regbits_t wb_regDst;
  word_t    wb_wdata;
  word_t    wb_pc_add4;
  logic     wb_halt;
  logic     mem_err;

  modport master (
    input  ex_valid, ex_dREN, ex_dWEN, ex_portOut, ex_portB_fwd, ex_regWr,
           ex_memToReg, ex_regDst, ex_halt, ex_pc_add4, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid,
           wb_regWr, wb_regDst, wb_wdata, wb_pc_add4, wb_halt, mem_err
  );

  modport slave (
    output ex_valid, ex_dREN, ex_dWEN, ex_portOut, ex_portB_fwd, ex_regWr,
           ex_memToReg, ex_regDst, ex_halt, ex_pc_add4, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, wb_valid,
           wb_regWr, wb_regDst, wb_wdata, wb_pc_add4, wb_halt, mem_err
  );

endinterface

// File: rtl/mem_stage_ctrl_wait_counter.sv
// ----------------------------------------------------------------------------
// mem_wait_counter
// Counts dcache wait cycles; saturates at MAX_WAIT.
//   CLK      in  clock
//   RST      in  synchronous active-high reset
//   clear_i  in  restart the count at zero (wins over en_i)
//   en_i     in  count one more wait cycle
//   expire_o out count equals MAX_WAIT after the coming edge
// expire_o looks at the next-state value so the owner can raise its error
// flag on the same edge that the count reaches MAX_WAIT.
// ----------------------------------------------------------------------------
module mem_wait_counter #(
  parameter int MAX_WAIT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_Q = MAX_WAIT[CW-1:0];

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_Q)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_d == MAX_Q);

endmodule

// File: rtl/mem_stage_ctrl.sv
// ----------------------------------------------------------------------------
// mem_stage_ctrl
// Consumer end of the EX/MEM register. Decodes the control word, runs the
// dcache request with a dhit handshake, stalls the front of the pipe while an
// access is outstanding and produces the registered MEM/WB word.
//   CLK  in  clock
//   RST  in  synchronous active-high reset
//   bus  master side of mem_stage_ctrl_if:
//        ex_*                   EX/MEM control word and operands
//        dhit/dmemload          dcache completion and load data
//        dmemREN/WEN/addr/store dcache request (registered)
//        mem_stall              freeze PC, IF/ID, ID/EX, EX/MEM
//        wb_*                   MEM/WB word, sticky wb_halt
//        mem_err                sticky illegal-control / watchdog flag
// ----------------------------------------------------------------------------
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  mem_stage_ctrl_if.master  bus
);

  memctrl_state_t state_q, state_d;
  memreq_t        req_q, req_d;
  memwb_t         wb_q, wb_d;
  logic           halt_q, halt_d;
  logic           err_q, err_d;
  logic           stall;
  logic           is_mem;
  logic           cnt_clear, cnt_en, expire;

  assign is_mem = bus.ex_dREN | bus.ex_dWEN;

  // The counter restarts on the cycle the access is accepted and only ticks
  // on ACCESS cycles that did not complete.
  assign cnt_clear = (state_q == IDLE) & bus.ex_valid & is_mem & ~bus.ex_halt;
  assign cnt_en    = (state_q == ACCESS) & ~bus.dhit;

  mem_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .CLK      (CLK),
    .RST      (RST),
    .clear_i  (cnt_clear),
    .en_i     (cnt_en),
    .expire_o (expire)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          if (bus.ex_halt) begin
            state_d = HALTED;
          end else if (is_mem) begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.dhit) begin
          state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: stall plus next values of request, MEM/WB and sticky flags
  always_comb begin
    req_d  = req_q;
    wb_d   = wb_q;
    halt_d = halt_q;
    err_d  = err_q;
    stall  = 1'b0;
    unique case (state_q)
      IDLE: begin
        wb_d.valid = 1'b0;
        if (bus.ex_valid) begin
          if (bus.ex_halt) begin
            // A halt swallows any memory op that came with it.
            halt_d = 1'b1;
            if (is_mem) begin
              err_d = 1'b1;
            end
          end else if (is_mem) begin
            stall          = 1'b1;
            // Read+write together is illegal: run it as a store and flag it.
            req_d.ren      = bus.ex_dREN & ~bus.ex_dWEN;
            req_d.wen      = bus.ex_dWEN;
            req_d.addr     = bus.ex_portOut;
            req_d.data     = bus.ex_portB_fwd;
            req_d.regwr    = bus.ex_regWr;
            req_d.memtoreg = bus.ex_memToReg;
            req_d.regdst   = bus.ex_regDst;
            req_d.pc_add4  = bus.ex_pc_add4;
            if (bus.ex_dREN && bus.ex_dWEN) begin
              err_d = 1'b1;
            end
          end else begin
            wb_d.valid   = 1'b1;
            wb_d.regwr   = bus.ex_regWr;
            wb_d.regdst  = bus.ex_regDst;
            wb_d.wdata   = bus.ex_portOut;
            wb_d.pc_add4 = bus.ex_pc_add4;
          end
        end
      end
      ACCESS: begin
        if (bus.dhit) begin
          wb_d.valid   = 1'b1;
          wb_d.regwr   = req_q.regwr;
          wb_d.regdst  = req_q.regdst;
          wb_d.wdata   = req_q.memtoreg ? bus.dmemload : req_q.addr;
          wb_d.pc_add4 = req_q.pc_add4;
        end else begin
          stall      = 1'b1;
          wb_d.valid = 1'b0;
          // Watchdog only reports; the access keeps waiting for dhit.
          if (expire) begin
            err_d = 1'b1;
          end
        end
      end
      HALTED: begin
        stall      = 1'b1;
        wb_d.valid = 1'b0;
        halt_d     = 1'b1;
      end
      default: begin
        wb_d.valid = 1'b0;
      end
    endcase
  end

  // Request, MEM/WB and sticky flag registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_q  <= '0;
      wb_q   <= '0;
      halt_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      wb_q   <= wb_d;
      halt_q <= halt_d;
      err_q  <= err_d;
    end
  end

  // Enables are gated by state so they drop on the edge that leaves ACCESS.
  assign bus.dmemREN    = (state_q == ACCESS) & req_q.ren;
  assign bus.dmemWEN    = (state_q == ACCESS) & req_q.wen;
  assign bus.dmemaddr   = req_q.addr;
  assign bus.dmemstore  = req_q.data;
  assign bus.mem_stall  = stall;
  assign bus.wb_valid   = wb_q.valid;
  assign bus.wb_regWr   = wb_q.regwr;
  assign bus.wb_regDst  = wb_q.regdst;
  assign bus.wb_wdata   = wb_q.wdata;
  assign bus.wb_pc_add4 = wb_q.pc_add4;
  assign bus.wb_halt    = halt_q;
  assign bus.mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl with MAX_WAIT = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(
    .MAX_WAIT (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_ex();
    bus.ex_valid     = 1'b0;
    bus.ex_dREN      = 1'b0;
    bus.ex_dWEN      = 1'b0;
    bus.ex_portOut   = 32'h0;
    bus.ex_portB_fwd = 32'h0;
    bus.ex_regWr     = 1'b0;
    bus.ex_memToReg  = 1'b0;
    bus.ex_regDst    = 5'd0;
    bus.ex_halt      = 1'b0;
    bus.ex_pc_add4   = 32'h0;
  endtask

  initial begin
    RST = 1'b1;
    clr_ex();
    bus.dhit     = 1'b0;
    bus.dmemload = 32'h0;
    tick();
    tick();
    @(negedge CLK);
    chk("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
    chk("rst_wb_halt",  32'(bus.wb_halt),  32'h0);
    chk("rst_mem_err",  32'(bus.mem_err),  32'h0);
    chk("rst_dmemREN",  32'(bus.dmemREN),  32'h0);
    chk("rst_stall",    32'(bus.mem_stall), 32'h0);
    chk("rst_wdata",    bus.wb_wdata,      32'h0);
    tick();
    RST = 1'b0;

    // add: one-cycle pass-through
    bus.ex_valid   = 1'b1;
    bus.ex_regWr   = 1'b1;
    bus.ex_regDst  = 5'd5;
    bus.ex_portOut = 32'h0000_0010;
    bus.ex_pc_add4 = 32'h0000_0044;
    @(negedge CLK);
    chk("add_stall_in", 32'(bus.mem_stall), 32'h0);
    chk("add_wbv_in",   32'(bus.wb_valid),  32'h0);
    tick();
    clr_ex();
    @(negedge CLK);
    chk("add_wb_valid", 32'(bus.wb_valid),  32'h1);
    chk("add_wdata",    bus.wb_wdata,       32'h10);
    chk("add_regdst",   32'(bus.wb_regDst), 32'h5);
    chk("add_regwr",    32'(bus.wb_regWr),  32'h1);
    chk("add_pc",       bus.wb_pc_add4,     32'h44);
    chk("add_stall",    32'(bus.mem_stall), 32'h0);
    tick();
    @(negedge CLK);
    chk("add_bubble",   32'(bus.wb_valid),  32'h0);

    // lw @0x100, dhit on third ACCESS cycle
    tick();
    bus.ex_valid    = 1'b1;
    bus.ex_dREN     = 1'b1;
    bus.ex_memToReg = 1'b1;
    bus.ex_regWr    = 1'b1;
    bus.ex_regDst   = 5'd7;
    bus.ex_portOut  = 32'h0000_0100;
    bus.ex_pc_add4  = 32'h0000_0048;
    @(negedge CLK);
    chk("lw_stall_in", 32'(bus.mem_stall), 32'h1);
    chk("lw_ren_idle", 32'(bus.dmemREN),   32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) clr_ex();
      bus.dhit     = (i == 2);
      bus.dmemload = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge CLK);
      chk("lw_ren",   32'(bus.dmemREN),   32'h1);
      chk("lw_addr",  bus.dmemaddr,       32'h100);
      chk("lw_stall", 32'(bus.mem_stall), (i == 2) ? 32'h0 : 32'h1);
    end
    tick();
    bus.dhit     = 1'b0;
    bus.dmemload = 32'h0;
    @(negedge CLK);
    chk("lw_wb_valid", 32'(bus.wb_valid),  32'h1);
    chk("lw_wdata",    bus.wb_wdata,       32'hDEAD_BEEF);
    chk("lw_regdst",   32'(bus.wb_regDst), 32'h7);
    chk("lw_regwr",    32'(bus.wb_regWr),  32'h1);
    chk("lw_pc",       bus.wb_pc_add4,     32'h48);
    chk("lw_ren_done", 32'(bus.dmemREN),   32'h0);
    chk("lw_stall_done", 32'(bus.mem_stall), 32'h0);
    chk("lw_err",      32'(bus.mem_err),   32'h0);

    // sw @0x200, dhit on first ACCESS cycle
    tick();
    bus.ex_valid     = 1'b1;
    bus.ex_dWEN      = 1'b1;
    bus.ex_portOut   = 32'h0000_0200;
    bus.ex_portB_fwd = 32'h1234_5678;
    bus.ex_pc_add4   = 32'h0000_004C;
    @(negedge CLK);
    chk("sw_stall_in", 32'(bus.mem_stall), 32'h1);
    chk("sw_wen_idle", 32'(bus.dmemWEN),   32'h0);
    tick();
    clr_ex();
    bus.dhit = 1'b1;
    @(negedge CLK);
    chk("sw_wen",   32'(bus.dmemWEN),   32'h1);
    chk("sw_ren",   32'(bus.dmemREN),   32'h0);
    chk("sw_store", bus.dmemstore,      32'h1234_5678);
    chk("sw_addr",  bus.dmemaddr,       32'h200);
    chk("sw_stall", 32'(bus.mem_stall), 32'h0);
    tick();
    bus.dhit = 1'b0;
    @(negedge CLK);
    chk("sw_wen_done", 32'(bus.dmemWEN), 32'h0);
    chk("sw_wb_valid", 32'(bus.wb_valid), 32'h1);
    chk("sw_regwr",    32'(bus.wb_regWr), 32'h0);
    chk("sw_wdata",    bus.wb_wdata,      32'h200);
    chk("sw_pc",       bus.wb_pc_add4,    32'h4C);

    // stray dhit while idle has no effect
    tick();
    bus.dhit     = 1'b1;
    bus.dmemload = 32'h55;
    @(negedge CLK);
    chk("stray_stall", 32'(bus.mem_stall), 32'h0);
    tick();
    bus.dhit     = 1'b0;
    bus.dmemload = 32'h0;
    @(negedge CLK);
    chk("stray_wb_valid", 32'(bus.wb_valid), 32'h0);
    chk("stray_wdata",    bus.wb_wdata,      32'h200);

    // watchdog: MAX_WAIT=4, dhit withheld 6 cycles
    tick();
    bus.ex_valid    = 1'b1;
    bus.ex_dREN     = 1'b1;
    bus.ex_memToReg = 1'b1;
    bus.ex_regWr    = 1'b1;
    bus.ex_regDst   = 5'd9;
    bus.ex_portOut  = 32'h0000_0300;
    bus.ex_pc_add4  = 32'h0000_0050;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) clr_ex();
      @(negedge CLK);
      chk("wd_stall", 32'(bus.mem_stall), 32'h1);
      chk("wd_err",   32'(bus.mem_err),   (k >= 5) ? 32'h1 : 32'h0);
    end
    tick();
    bus.dhit     = 1'b1;
    bus.dmemload = 32'hCAFE_0001;
    @(negedge CLK);
    chk("wd_stall_hit", 32'(bus.mem_stall), 32'h0);
    tick();
    bus.dhit     = 1'b0;
    bus.dmemload = 32'h0;
    @(negedge CLK);
    chk("wd_wb_valid", 32'(bus.wb_valid),  32'h1);
    chk("wd_wdata",    bus.wb_wdata,       32'hCAFE_0001);
    chk("wd_regdst",   32'(bus.wb_regDst), 32'h9);
    chk("wd_err_held", 32'(bus.mem_err),   32'h1);

    // reset in the middle of an access
    tick();
    bus.ex_valid   = 1'b1;
    bus.ex_dREN    = 1'b1;
    bus.ex_regDst  = 5'd3;
    bus.ex_portOut = 32'h0000_0400;
    tick();
    clr_ex();
    @(negedge CLK);
    chk("mr_ren",  32'(bus.dmemREN), 32'h1);
    chk("mr_addr", bus.dmemaddr,     32'h400);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("mr_ren_rst",    32'(bus.dmemREN),   32'h0);
    chk("mr_wb_valid",   32'(bus.wb_valid),  32'h0);
    chk("mr_wdata",      bus.wb_wdata,       32'h0);
    chk("mr_regdst",     32'(bus.wb_regDst), 32'h0);
    chk("mr_pc",         bus.wb_pc_add4,     32'h0);
    chk("mr_err",        32'(bus.mem_err),   32'h0);
    chk("mr_stall",      32'(bus.mem_stall), 32'h0);
    chk("mr_addr_rst",   bus.dmemaddr,       32'h0);

    // halt: absorbing, keeps stalling, ignores later instructions
    tick();
    bus.ex_valid   = 1'b1;
    bus.ex_halt    = 1'b1;
    bus.ex_pc_add4 = 32'h0000_0060;
    @(negedge CLK);
    chk("halt_stall_in", 32'(bus.mem_stall), 32'h0);
    tick();
    bus.ex_halt    = 1'b0;
    bus.ex_regWr   = 1'b1;
    bus.ex_portOut = 32'h0000_0077;
    @(negedge CLK);
    chk("halt_wb_halt", 32'(bus.wb_halt),   32'h1);
    chk("halt_stall",   32'(bus.mem_stall), 32'h1);
    chk("halt_wb_valid", 32'(bus.wb_valid), 32'h0);
    chk("halt_err",     32'(bus.mem_err),   32'h0);
    for (int j = 0; j < 2; j++) begin
      tick();
      @(negedge CLK);
      chk("halt_sticky",   32'(bus.wb_halt),  32'h1);
      chk("halt_no_wb",    32'(bus.wb_valid), 32'h0);
      chk("halt_no_req",   32'(bus.dmemREN),  32'h0);
    end

    // halt together with a load: access dropped, error flagged
    tick();
    RST = 1'b1;
    clr_ex();
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("halt_rst", 32'(bus.wb_halt), 32'h0);
    tick();
    bus.ex_valid   = 1'b1;
    bus.ex_halt    = 1'b1;
    bus.ex_dREN    = 1'b1;
    bus.ex_portOut = 32'h0000_0500;
    tick();
    clr_ex();
    @(negedge CLK);
    chk("hld_wb_halt", 32'(bus.wb_halt),   32'h1);
    chk("hld_err",     32'(bus.mem_err),   32'h1);
    chk("hld_ren",     32'(bus.dmemREN),   32'h0);
    chk("hld_stall",   32'(bus.mem_stall), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
